// File: rtl/data_mem_responder.sv
// Single-port data memory responder for the load/store stage.
// One request at a time, programmable wait states, registered response.
module data_mem_responder #(
  parameter int ADDR_W   = 6,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        Mem_Req,
  input  logic        Mem_Write,
  input  logic        Mem_Byte,
  input  logic [31:0] Mem_Addr,
  input  logic [31:0] Mem_WData,
  output logic        Mem_Ready,
  output logic [31:0] Mem_RData,
  output logic        Mem_Err,
  output logic        Busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LD =
    (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [3:0]  cnt;
  logic        r_write;
  logic        r_byte;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] mem [DEPTH];

  logic st_idle;
  logic st_wait;
  logic st_resp;
  logic accept;
  logic go_resp;

  assign st_idle = (state == IDLE);
  assign st_wait = (state == WAIT);
  assign st_resp = (state == RESP);
  assign accept  = st_idle && Mem_Req;
  assign go_resp = (st_wait && cnt == 4'd0)
                || (accept && WAIT_CYC == 0);

  function automatic logic addr_err(
    input logic [31:0] a,
    input logic        b
  );
    return ((a >> (ADDR_W + 2)) != '0)
        || (!b && a[1:0] != 2'b00);
  endfunction

  // With zero wait states the write lands on the accepting edge,
  // before the request registers hold anything, so use the inputs.
  logic              c_write;
  logic              c_byte;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic              c_err;
  logic [ADDR_W-1:0] c_idx;
  logic [1:0]        c_lane;
  logic              do_wr;

  assign c_write = st_idle ? Mem_Write : r_write;
  assign c_byte  = st_idle ? Mem_Byte  : r_byte;
  assign c_addr  = st_idle ? Mem_Addr  : r_addr;
  assign c_wdata = st_idle ? Mem_WData : r_wdata;
  assign c_err   = addr_err(c_addr, c_byte);
  assign c_idx   = c_addr[ADDR_W+1:2];
  assign c_lane  = c_addr[1:0];
  assign do_wr   = go_resp && c_write && !c_err;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      st_idle: if (Mem_Req) state_nxt = (WAIT_CYC > 0) ? WAIT : RESP;
      st_wait: if (cnt == 4'd0) state_nxt = RESP;
      st_resp: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      Busy    <= 1'b0;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      state <= state_nxt;
      Busy  <= (state_nxt != IDLE);
      if (accept) begin
        r_write <= Mem_Write;
        r_byte  <= Mem_Byte;
        r_addr  <= Mem_Addr;
        r_wdata <= Mem_WData;
        cnt     <= WAIT_LD;
      end else if (st_wait && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_wr) begin
      if (c_byte) mem[c_idx][{c_lane, 3'b000} +: 8] <= c_wdata[7:0];
      else        mem[c_idx] <= c_wdata;
    end
  end

  logic              r_err;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [31:0]       load_data;

  assign r_err     = addr_err(r_addr, r_byte);
  assign r_idx     = r_addr[ADDR_W+1:2];
  assign rd_word   = mem[r_idx];
  assign rd_byte   = 8'(rd_word >> {r_addr[1:0], 3'b000});
  assign load_data = r_byte ? {24'b0, rd_byte} : rd_word;

  // Response is registered out of RESP, so Ready trails RESP by a cycle.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      Mem_Ready <= 1'b0;
      Mem_Err   <= 1'b0;
      Mem_RData <= '0;
    end else begin
      Mem_Ready <= st_resp;
      Mem_Err   <= st_resp && r_err;
      Mem_RData <= (st_resp && !r_err && !r_write) ? load_data : '0;
    end
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Single-port data memory that answers the CPU's load/store accesses over a request/ready handshake.
- It is the responder end of the memory interface the multi-cycle ARM core drives in the load/store stage.
- It latches one request, inserts a programmable number of wait states, then performs the read or write and returns one registered response. Out-of-range or misaligned accesses are reported with an error flag.
- It supports word and byte accesses, little-endian.

## Interface
Parameters:
- ADDR_W, 6, word-address bits; memory holds 2^ADDR_W 32-bit words (byte range 0 .. 4*2^ADDR_W-1).
- WAIT_CYC, 2, wait states inserted before each response; legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  reset; asynchronous, active-low.
- Mem_Req  input  1  request valid; sampled only in IDLE.
- Mem_Write  input  1  1 = store, 0 = load.
- Mem_Byte  input  1  1 = byte access, 0 = word access.
- Mem_Addr  input  32  byte address.
- Mem_WData  input  32  store data; byte stores use bits [7:0].
- Mem_Ready  output  1  one-cycle response strobe.
- Mem_RData  output  32  load data, valid while Mem_Ready=1, otherwise 0.
- Mem_Err  output  1  access rejected, valid while Mem_Ready=1.
- Busy  output  1  1 in WAIT and RESP.

## Operation
- FSM states and transitions:
  - IDLE: if Mem_Req=1, latch Write, Byte, Addr and WData into request registers. Go to WAIT if WAIT_CYC>0, else go to RESP.
  - WAIT: counter loaded with WAIT_CYC-1 on entry and decrements each cycle. Go to RESP when the counter is 0.
  - RESP: Mem_Ready=1 for exactly one cycle, then go to IDLE.
- Requests arriving outside IDLE are ignored, not queued.
- Mem_Req still high in the cycle after RESP (back in IDLE) is a new request. The initiator must drop Mem_Req in the Ready cycle unless it wants back-to-back accesses.
- Error check, evaluated on the latched request:
  - Mem_Addr[31:ADDR_W+2] nonzero: out of range.
  - Word access with Addr[1:0] != 2'b00: misaligned.
  - Either condition sets Err=1.
- On Err: no memory write, RData=0.
- Load word: RData = mem[Addr[ADDR_W+1:2]].
- Load byte: RData = {24'b0, lane}, where lane = Addr[1:0]. Lane 0 = bits [7:0], lane 3 = bits [31:24]. Zero-extended.
- Store word: the whole word is written.
- Store byte: only the selected lane is written from WData[7:0]; other lanes are unchanged.
- A store returns RData=0.
- The memory write happens on the clock edge that enters RESP. A load issued after a store therefore sees the new data.
- Address arithmetic ignores Addr[1:0] for indexing. No wrap-around: out-of-range addresses error, they do not alias.

## Timing
- Reset (Rst=0, asynchronous): state=IDLE, counter=0, Mem_Ready=0, Mem_RData=0, Mem_Err=0, Busy=0, all memory words cleared to 0.
- Reset mid-WAIT discards the pending access; no write occurs.
- Outputs are all registered, with no combinational path from inputs to outputs.
- Latency: for a request accepted at edge k, Mem_Ready is high between edges k+1+WAIT_CYC and k+2+WAIT_CYC.
  - WAIT_CYC=2: Ready in the third cycle after acceptance.
  - WAIT_CYC=0: Ready in the first cycle after acceptance.
- Throughput: at most one access per WAIT_CYC+2 cycles. Busy goes high the cycle after acceptance and low with the return to IDLE.
- Mem_RData and Mem_Err return to 0 the cycle after Ready.
- Input changes while Busy=1 have no effect on the pending access.

## Test plan
- Reset, then store word 0xDEADBEEF at 0x08, then load word at 0x08 (WAIT_CYC=2). Required: each Ready arrives exactly 3 cycles after acceptance, Err=0, and the load returns 0xDEADBEEF.
- Byte stores: 0x11 to address 0x10 and 0xAA to 0x13. Required:
  - Load word at 0x10 returns 0xAA000011.
  - Load byte at 0x13 returns 0x000000AA.
  - Load byte at 0x11 returns 0x00000000.
- Misaligned and out-of-range accesses:
  - Word store to 0x06: Ready with Err=1, and a later load of 0x04 is unchanged.
  - Load at 0x100 (ADDR_W=6): Err=1, RData=0.
  - Byte load at 0x05: Err=0.
- Back-to-back requests: Mem_Req held high across two accesses. Required: the second access is accepted in the IDLE cycle after Ready, and pulses on Mem_Req during WAIT create no extra responses.
- Reset mid-operation: assert Rst=0 during WAIT of a word store of 0x12345678 to 0x0C. Required: outputs go to 0 immediately and a later load of 0x0C returns 0.
- WAIT_CYC=0 build: store followed by load. Required: Ready one cycle after each acceptance, Busy high exactly one cycle per access.
